instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, word address loaded into the PC on reset.
REQ-002 Parameter WIDTH, default 16, instruction and address width; only 16 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  16  word address of the requested instruction.
REQ-007 imem_rdata  input  16  instruction word; valid when imem_ready=1.
REQ-008 imem_ready  input  1  memory response strobe; sampled only while imem_req=1.
REQ-009 stall  input  1  downstream hold; the current instruction is not consumed.
REQ-010 Branch  input  1  control-unit branch flag for the instruction on instr.
REQ-011 branch_taken  input  1  datapath compare result for beq/bne.
REQ-012 branch_target  input  16  datapath-computed branch address.
REQ-013 Jump  input  1  control-unit jump flag for the instruction on instr.
REQ-014 instr  output  16  registered instruction word.
REQ-015 opcode  output  4  instr[15:12], drives control_unit opcode.
REQ-016 function_code  output  4  instr[3:0], drives control_unit function_code.
REQ-017 pc_out  output  16  address of the instruction on instr.
REQ-018 instr_valid  output  1  instr/pc_out hold a live instruction.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ and VALID.
- IDLE: one cycle after reset, then REQ.
- REQ: imem_req=1, imem_addr=pc.
- VALID: instr_valid=1.
REQ-020 In REQ with imem_ready=1, the block SHALL capture imem_rdata into instr and pc into pc_out, then enter VALID next cycle; with imem_ready=0 it SHALL stay in REQ with the address held.
REQ-021 In VALID with stall=1, the block SHALL hold state, instr, pc_out and instr_valid unchanged.
REQ-022 In VALID with stall=0, the block SHALL update pc and return to REQ:
- Jump=1: pc <= {pc_out[15:12], instr[11:0]}.
- else Branch&branch_taken=1: pc <= branch_target.
- else: pc <= pc_out+1, wrapping 16'hFFFF to 16'h0000.
REQ-023 If Jump and Branch are both 1, Jump SHALL win.
REQ-024 Branch, branch_taken, branch_target and Jump SHALL be ignored outside VALID and while stall=1.
REQ-025 instr_valid SHALL be 0 in IDLE and REQ.
REQ-026 opcode and function_code SHALL be pure slices of instr.
REQ-027 Minimum throughput SHALL be one instruction per two cycles, occurring when imem_ready=1 in the first REQ cycle.

Reset
REQ-028 Asserting rst_n=0 at any time, including mid-REQ, SHALL immediately force the following values:
- state=IDLE
- pc=RESET_PC
- imem_req=0
- imem_addr=RESET_PC
- instr=16'h0000
- pc_out=16'h0000
- instr_valid=0
REQ-029 A memory response arriving during or after reset for a pre-reset request SHALL be discarded.

Configuration
REQ-030 With IFETCH_PERF_EN defined, the block SHALL add two ports:
- fetch_count output 16: increments on each VALID&!stall cycle and saturates at 16'hFFFF.
- mem_wait_count output 16: increments on each REQ&!imem_ready cycle and saturates.
Both counters SHALL reset to 0.
REQ-031 Without IFETCH_PERF_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 The shared package proc_pkg SHALL hold:
- opcode constants: RTYPE=4'b0000, LW=0001, SW=0010, ADDI=0011, BEQ=0100, BNE=0101, JMP=0110;
- instruction field positions;
- the fetch state enum.
REQ-033 Next-PC selection SHALL live in a combinational sub-module pc_next_logic: inputs pc_out, instr, Jump, Branch, branch_taken, branch_target; output next_pc.

Verification
REQ-034 Release reset with RESET_PC=0 and imem_ready tied 1, returning 16'h0123 at address 0 -> imem_addr=0 in cycle 2, instr_valid=1 in cycle 3, opcode=0000, function_code=0011, pc_out=0.
REQ-035 Hold imem_ready=0 for 3 REQ cycles at pc=5 -> imem_addr stays 5, instr_valid=0, and mem_wait_count=3 when IFETCH_PERF_EN is defined.
REQ-036 At VALID for instr 16'h6ABC with pc_out=16'h7010, Jump=1 and stall=0 -> next imem_addr=16'h7ABC.
REQ-037 beq at pc_out=16'h0020 with branch_taken=0 -> next imem_addr=16'h0021; repeat with branch_taken=1 and branch_target=16'h0040 -> next imem_addr=16'h0040.
REQ-038 stall=1 for 4 cycles in VALID with Jump toggling -> instr, pc_out and instr_valid stable; after stall=0, the address follows Jump as sampled that cycle.
REQ-039 pc_out=16'hFFFF with a sequential instruction -> next imem_addr=16'h0000; assert rst_n=0 mid-REQ -> all outputs take reset values without waiting for clk.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions and the
// instruction-fetch state encoding.
package proc_pkg;

   localparam int INSTR_W = 16;

   localparam logic [3:0] RTYPE = 4'b0000;
   localparam logic [3:0] LW    = 4'b0001;
   localparam logic [3:0] SW    = 4'b0010;
   localparam logic [3:0] ADDI  = 4'b0011;
   localparam logic [3:0] BEQ   = 4'b0100;
   localparam logic [3:0] BNE   = 4'b0101;
   localparam logic [3:0] JMP   = 4'b0110;

   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;
   localparam int FUNCT_MSB  = 3;
   localparam int FUNCT_LSB  = 0;
   localparam int JADDR_MSB  = 11;
   localparam int JADDR_LSB  = 0;
   // Jumps stay inside the current 4K-word page held in these pc bits.
   localparam int PAGE_MSB   = 15;
   localparam int PAGE_LSB   = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module pc_next_logic
   import proc_pkg::*;
(
   input  logic [INSTR_W-1:0] pc_out,
   input  logic [INSTR_W-1:0] instr,
   input  logic               Jump,
   input  logic               Branch,
   input  logic               branch_taken,
   input  logic [INSTR_W-1:0] branch_target,
   output logic [INSTR_W-1:0] next_pc
);

   // The opcode field plays no part in target selection.
   logic unused_opcode_bits;
   assign unused_opcode_bits = ^instr[OPCODE_MSB:OPCODE_LSB];

   always_comb begin
      next_pc = pc_out + 16'd1;
      if (Jump) begin
         next_pc = {pc_out[PAGE_MSB:PAGE_LSB], instr[JADDR_MSB:JADDR_LSB]};
      end else if (Branch && branch_taken) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE -> REQ -> VALID loop with registered instruction.
// Define IFETCH_PERF_EN to add the fetch_count / mem_wait_count counters.
module instruction_fetch
   import proc_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          WIDTH    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             imem_ready,
   input  logic             stall,
   input  logic             Branch,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             Jump,
   output logic [WIDTH-1:0] instr,
   output logic [3:0]       opcode,
   output logic [3:0]       function_code,
   output logic [WIDTH-1:0] pc_out,
   output logic             instr_valid,
   output fetch_state_t     state_dbg
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]      fetch_count,
   output logic [15:0]      mem_wait_count
`endif
);

   // Handshake: a request is held (imem_req=1, imem_addr stable) until a cycle
   // with imem_ready=1; imem_ready is ignored whenever imem_req=0. A live
   // instruction (instr_valid=1) is consumed on the first cycle with stall=0.

   fetch_state_t     state, state_next;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] next_pc;
   logic             load_instr;
   logic             advance;

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      load_instr  = 1'b0;
      advance     = 1'b0;
      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               load_instr = 1'b1;
               state_next = VALID;
            end
         end
         VALID: begin
            instr_valid = 1'b1;
            if (!stall) begin
               advance    = 1'b1;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         instr  <= '0;
         pc_out <= '0;
      end else begin
         state <= state_next;
         if (load_instr) begin
            instr  <= imem_rdata;
            pc_out <= pc;
         end
         if (advance) begin
            pc <= next_pc;
         end
      end
   end

   pc_next_logic u_pc_next_logic (
      .pc_out        (pc_out),
      .instr         (instr),
      .Jump          (Jump),
      .Branch        (Branch),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc)
   );

   assign imem_addr     = pc;
   assign opcode        = instr[OPCODE_MSB:OPCODE_LSB];
   assign function_code = instr[FUNCT_MSB:FUNCT_LSB];
   assign state_dbg     = state;

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count    <= '0;
         mem_wait_count <= '0;
      end else begin
         if (advance && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
         end
         if (imem_req && !imem_ready && (mem_wait_count != 16'hFFFF)) begin
            mem_wait_count <= mem_wait_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder, fetch-sequence reference model,
// scoreboard queue of expected {pc, instr} fetches and a decoupled monitor.
module tb_instruction_fetch;
   import proc_pkg::*;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        Branch;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        Jump;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [3:0]  function_code;
   logic [15:0] pc_out;
   logic        instr_valid;
   fetch_state_t state_dbg;
`ifdef IFETCH_PERF_EN
   logic [15:0] fetch_count;
   logic [15:0] mem_wait_count;
`endif

   instruction_fetch #(.RESET_PC(RESET_PC), .WIDTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .stall         (stall),
      .Branch        (Branch),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .Jump          (Jump),
      .instr         (instr),
      .opcode        (opcode),
      .function_code (function_code),
      .pc_out        (pc_out),
      .instr_valid   (instr_valid),
      .state_dbg     (state_dbg)
`ifdef IFETCH_PERF_EN
      ,
      .fetch_count   (fetch_count),
      .mem_wait_count(mem_wait_count)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   logic [15:0] mem [0:65535];
   logic [31:0] exp_q[$];
   logic [15:0] model_pc;
   int          checks;
   int          errors;
   int          ready_low_cycles;
   bit          rand_ready;
   bit          mon_en;
   int          exp_fetch;
   int          exp_wait;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Architectural next-address rule for the instruction at cur.
   function automatic logic [15:0] ref_next(input logic [15:0] cur, input logic [15:0] ins,
                                            input logic j, input logic b, input logic t,
                                            input logic [15:0] tgt);
      if (j) return {cur[15:12], ins[11:0]};
      if (b && t) return tgt;
      return 16'(cur + 16'd1);
   endfunction

   // ---------------- memory responder ----------------
   always @(negedge clk) begin
      if (imem_req) begin
         if (ready_low_cycles > 0) begin
            imem_ready = 1'b0;
            ready_low_cycles--;
         end else if (rand_ready) begin
            imem_ready = ($urandom_range(0, 3) != 0);
         end else begin
            imem_ready = 1'b1;
         end
         if (imem_ready) imem_rdata = mem[imem_addr];
         else begin
            imem_rdata = 16'($urandom);
            exp_wait++;
         end
      end else begin
         imem_ready = 1'($urandom);
         imem_rdata = 16'($urandom);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic        last_valid;
   logic [15:0] cur_pc;
   logic [15:0] cur_instr;

   always @(negedge clk) begin
      if (!mon_en) begin
         last_valid = 1'b0;
      end else begin
         if (imem_req) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL req_unexpected actual=%h expected=none", imem_addr);
            end else begin
               check("req_addr", imem_addr, exp_q[0][31:16]);
            end
            check("req_valid_low", 16'(instr_valid), 16'd0);
         end
         if (instr_valid && !last_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fetch_unexpected actual=%h expected=none", pc_out);
            end else begin
               {cur_pc, cur_instr} = exp_q.pop_front();
               check("pc_out", pc_out, cur_pc);
               check("instr", instr, cur_instr);
               check("opcode", 16'(opcode), 16'(cur_instr[15:12]));
               check("function_code", 16'(function_code), 16'(cur_instr[3:0]));
            end
         end else if (instr_valid) begin
            check("hold_instr", instr, cur_instr);
            check("hold_pc_out", pc_out, cur_pc);
         end
         last_valid = instr_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic randomize_flags();
      stall         = 1'($urandom);
      Jump          = 1'($urandom);
      Branch        = 1'($urandom);
      branch_taken  = 1'($urandom);
      branch_target = 16'($urandom);
   endtask

   // Wait for a live instruction, stall it, then consume it with the given flags.
   task automatic step(input int stall_cycles, input logic j, input logic b, input logic t,
                       input logic [15:0] tgt);
      int n;
      logic [15:0] nxt;
      n = 0;
      while (!instr_valid && n < 200) begin
         randomize_flags();
         @(negedge clk);
         n++;
      end
      if (!instr_valid) begin
         checks++;
         errors++;
         $display("FAIL step_timeout actual=%0d expected<200 cycles", n);
         return;
      end
      for (int i = 0; i < stall_cycles; i++) begin
         stall         = 1'b1;
         Jump          = i[0];
         Branch        = 1'($urandom);
         branch_taken  = 1'($urandom);
         branch_target = 16'($urandom);
         @(negedge clk);
      end
      stall         = 1'b0;
      Jump          = j;
      Branch        = b;
      branch_taken  = t;
      branch_target = tgt;
      nxt = ref_next(model_pc, mem[model_pc], j, b, t, tgt);
      model_pc = nxt;
      exp_q.push_back({nxt, mem[nxt]});
      exp_fetch++;
      @(negedge clk);
      randomize_flags();
   endtask

   task automatic arm_after_reset();
      exp_q.delete();
      model_pc = RESET_PC;
      exp_q.push_back({RESET_PC, mem[RESET_PC]});
      exp_fetch = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      checks = 0; errors = 0; ready_low_cycles = 0; rand_ready = 1'b0; mon_en = 1'b0;
      exp_fetch = 0; exp_wait = 0;
      rst_n = 1'b0; stall = 1'b0; Jump = 1'b0; Branch = 1'b0; branch_taken = 1'b0;
      branch_target = 16'h0; imem_ready = 1'b0; imem_rdata = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h0000] = 16'h0123;
      mem[16'h7010] = 16'h6ABC;
      mem[16'h0020] = 16'h4567;
      mem[16'hFFFF] = 16'h3001;

      repeat (3) @(negedge clk);
      check("rst_req", 16'(imem_req), 16'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_instr", instr, 16'h0000);
      check("rst_pc_out", pc_out, 16'h0000);
      check("rst_valid", 16'(instr_valid), 16'd0);
      check("rst_state", 16'(state_dbg), 16'(IDLE));

      arm_after_reset();
      exp_wait = 0;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check("first_req", 16'(imem_req), 16'd1);
      check("first_addr", imem_addr, 16'h0000);
      @(negedge clk);
      check("first_valid", 16'(instr_valid), 16'd1);
      check("first_opcode", 16'(opcode), 16'h0000);
      check("first_funct", 16'(function_code), 16'h0003);

      ready_low_cycles = 3;
      step(0, 1'b0, 1'b1, 1'b1, 16'h0005);
      step(0, 1'b0, 1'b1, 1'b1, 16'h7010);
`ifdef IFETCH_PERF_EN
      check("mem_wait_3", mem_wait_count, 16'd3);
`endif
      step(0, 1'b1, 1'b0, 1'b0, 16'h0000);
      step(0, 1'b0, 1'b1, 1'b1, 16'h0020);
      step(0, 1'b0, 1'b1, 1'b0, 16'h0040);
      step(0, 1'b0, 1'b1, 1'b1, 16'h0020);
      step(0, 1'b0, 1'b1, 1'b1, 16'h0040);
      step(4, 1'b1, 1'b1, 1'b1, 16'h1234);
      step(3, 1'b0, 1'b1, 1'b1, 16'hFFFF);
      step(0, 1'b0, 1'b0, 1'b0, 16'h0000);

      rand_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         step($urandom_range(0, 2), ($urandom_range(0, 3) == 0), 1'($urandom),
              1'($urandom), 16'($urandom));
      end

      // Asynchronous reset in the middle of a held request.
      n = 0;
      while (!instr_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      step(0, 1'b0, 1'b0, 1'b0, 16'h0000);
      ready_low_cycles = 5;
      @(negedge clk);
      check("pre_reset_req", 16'(imem_req), 16'd1);
      mon_en = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_wait = 0;
      #1;
      check("async_req", 16'(imem_req), 16'd0);
      check("async_addr", imem_addr, RESET_PC);
      check("async_instr", instr, 16'h0000);
      check("async_pc_out", pc_out, 16'h0000);
      check("async_valid", 16'(instr_valid), 16'd0);
      check("async_state", 16'(state_dbg), 16'(IDLE));
`ifdef IFETCH_PERF_EN
      check("async_fetch_cnt", fetch_count, 16'd0);
      check("async_wait_cnt", mem_wait_count, 16'd0);
`endif
      ready_low_cycles = 0;
      @(negedge clk);
      @(negedge clk);
      arm_after_reset();
      exp_wait = 0;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step($urandom_range(0, 2), ($urandom_range(0, 3) == 0), 1'($urandom),
              1'($urandom), 16'($urandom));
      end
`ifdef IFETCH_PERF_EN
      check("fetch_count", fetch_count, 16'(exp_fetch));
      check("mem_wait_count", mem_wait_count, 16'(exp_wait));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
